// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage:
//                the fetch bundle handed to decode, the fetch FSM state
//                encoding and the sequential PC increment.
//  Macros      : FETCH_MISALIGN_EXC_EN (consumed by fetch_unit)
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] raw_instr;
      logic        exc;
   } fetch_bundle_t;

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2,
      HALT    = 2'd3
   } fetch_state_t;

   localparam logic [63:0] PC_STEP = 64'd4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : 2-entry FIFO of fetch bundles. Entry 0 is always the head,
//                so a pop shifts entry 1 down. Flush wins over push.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                i_push   - write i_din this cycle
//                i_pop    - remove the head this cycle (ignored when empty)
//                i_flush  - empty the FIFO (overrides push and pop)
//                i_din    - bundle to write
//                o_count  - occupancy, 0..2
//                o_head   - oldest bundle (cleared to zero by reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  fetch_bundle_t i_din,
   output logic [1:0]    o_count,
   output fetch_bundle_t o_head
);

   logic [1:0]    r_count;
   fetch_bundle_t r_mem0;
   fetch_bundle_t r_mem1;
   logic          w_pop;

   assign w_pop = i_pop && (r_count != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 2'd0;
         r_mem0  <= '0;
         r_mem1  <= '0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_mem0 <= i_din;
               else                 r_mem1 <= i_din;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_mem0  <= r_mem1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the new bundle lands behind whatever
               // remains after the head leaves.
               if (r_count == 2'd2) begin
                  r_mem0 <= r_mem1;
                  r_mem1 <= i_din;
               end else begin
                  r_mem0 <= i_din;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem0;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues one outstanding
//                word read at a time, buffers up to two fetched bundles for
//                decode and drops stale responses after a redirect.
//  Macros      : FETCH_MISALIGN_EXC_EN - when defined, a misaligned PC emits
//                one exception bundle and halts fetch until a redirect; when
//                undefined, loaded PCs are forced word aligned.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                ireq_valid/addr/ready      - instruction read request
//                iresp_valid/data           - instruction read response
//                redirect_valid/pc          - branch/jump redirect
//                out_valid/ready            - handshake to decode
//                out_raw_instr/pc/exc       - head fetch bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
)(
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_raw_instr,
   output logic [63:0] out_pc,
   output logic        out_exc
);

`ifdef FETCH_MISALIGN_EXC_EN
   localparam logic [63:0] c_ALIGN_MASK = '1;
`else
   localparam logic [63:0] c_ALIGN_MASK = {{62{1'b1}}, 2'b00};
`endif

   fetch_state_t  r_state;
   fetch_state_t  w_next_state;
   logic [63:0]   r_pc;
   logic [63:0]   w_pc_next;
   logic          w_req;
   logic          w_space;
   logic          w_push;
   logic          w_pop;
   logic          w_flush;
   fetch_bundle_t w_push_data;
   fetch_bundle_t w_head;
   logic [1:0]    w_count;

`ifdef FETCH_MISALIGN_EXC_EN
   logic w_misalign;
   assign w_misalign = (r_pc[1:0] != 2'b00);
`endif

   assign w_space = (w_count != 2'd2);

   always_comb begin
      w_next_state = r_state;
      w_pc_next    = r_pc;
      w_req        = 1'b0;
      w_push       = 1'b0;
      w_flush      = 1'b0;
      w_push_data  = '0;

      case (r_state)
         REQ: begin
`ifdef FETCH_MISALIGN_EXC_EN
            w_req = w_space && !w_misalign;
            if (w_misalign && w_space) begin
               w_push                = 1'b1;
               w_push_data.pc        = r_pc;
               w_push_data.exc       = 1'b1;
               w_next_state          = HALT;
            end
`else
            w_req = w_space;
`endif
            if (w_req && ireq_ready) w_next_state = WAIT;
         end
         WAIT: begin
            if (iresp_valid) begin
               w_push                = 1'b1;
               w_push_data.pc        = r_pc;
               w_push_data.raw_instr = iresp_data;
               w_pc_next             = r_pc + PC_STEP;
               w_next_state          = REQ;
            end
         end
         DISCARD: begin
            if (iresp_valid) w_next_state = REQ;
         end
`ifdef FETCH_MISALIGN_EXC_EN
         HALT: ;
`endif
         default: w_next_state = REQ;
      endcase

      // Redirect overrides everything decided above.
      if (redirect_valid) begin
         w_flush   = 1'b1;
         w_push    = 1'b0;
         w_pc_next = redirect_pc & c_ALIGN_MASK;
         case (r_state)
            REQ:     w_next_state = (w_req && ireq_ready) ? DISCARD : REQ;
            WAIT:    w_next_state = iresp_valid ? REQ : DISCARD;
            DISCARD: w_next_state = DISCARD;
            default: w_next_state = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= REQ;
         r_pc    <= PC_RESET & c_ALIGN_MASK;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_pc_next;
      end
   end

   // A pop in a redirect cycle is meaningless; the flush already empties it.
   assign w_pop = out_valid && out_ready && !redirect_valid;

   fetch_fifo u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_din   (w_push_data),
      .o_count (w_count),
      .o_head  (w_head)
   );

   // The state may sit in REQ during reset; keep the bus quiet then.
   assign ireq_valid    = w_req && !reset;
   assign ireq_addr     = r_pc;
   assign out_valid     = (w_count != 2'd0);
   assign out_raw_instr = w_head.raw_instr;
   assign out_pc        = w_head.pc;
   // Without the misalign feature only exc=0 bundles are ever written and
   // reset clears the head, so this stays 0 in that build.
   assign out_exc       = w_head.exc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed bench for fetch_unit with a simple instruction
//                memory model of configurable latency. Returned data is
//                addr[31:0] ^ 32'h13 so bundle order is visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        ireq_ready;
   logic        iresp_valid;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_raw_instr;
   logic [63:0] out_pc;
   logic        out_exc;

   int total = 0;
   int bad   = 0;

   // memory model state
   int          mem_lat = 1;
   logic        pend    = 1'b0;
   int          pend_cnt = 0;
   logic [63:0] pend_addr = '0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .ireq_ready     (ireq_ready),
      .iresp_valid    (iresp_valid),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_raw_instr  (out_raw_instr),
      .out_pc         (out_pc),
      .out_exc        (out_exc)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample the request handshake, cross the edge, then
   // update the memory model for the new cycle.
   task automatic tick();
      logic        acc;
      logic [63:0] a;
      #1;
      acc = ireq_valid && ireq_ready;
      a   = ireq_addr;
      total++;
      assert (!(dut.w_push && dut.w_count == 2'd2)) else begin
         bad++;
         $error("FAIL overflow: push into full buffer observed=1 expected=0");
      end
      @(posedge clk);
      #1;
      iresp_valid = 1'b0;
      if (acc) begin
         pend      = 1'b1;
         pend_cnt  = mem_lat;
         pend_addr = a;
      end
      if (reset) pend = 1'b0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            iresp_valid = 1'b1;
            iresp_data  = pend_addr[31:0] ^ 32'h13;
            pend        = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      ireq_ready     = 1'b0;
      iresp_valid    = 1'b0;
      iresp_data     = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      tick();
      tick();
      // during reset
      check("rst_ireq_valid", ireq_valid, 0);
      check("rst_out_valid",  out_valid, 0);
      check("rst_out_pc",     out_pc, 0);
      check("rst_out_raw",    out_raw_instr, 0);
      check("rst_out_exc",    out_exc, 0);

      // C0: first cycle out of reset, decode stalled
      ireq_ready = 1'b1;
      reset      = 1'b0;
      #1;
      check("c0_ireq_valid", ireq_valid, 1);
      check("c0_ireq_addr",  ireq_addr, 64'h8000_0000);
      tick(); // C1
      check("c1_ireq_valid", ireq_valid, 0);
      check("c1_out_valid",  out_valid, 0);
      tick(); // C2
      check("c2_out_valid",  out_valid, 1);
      check("c2_out_pc",     out_pc, 64'h8000_0000);
      check("c2_out_raw",    out_raw_instr, 32'h8000_0013);
      check("c2_ireq_addr",  ireq_addr, 64'h8000_0004);
      tick(); // C3
      tick(); // C4: buffer full
      check("c4_ireq_valid", ireq_valid, 0);
      check("c4_out_pc",     out_pc, 64'h8000_0000);
      tick(); // C5
      check("c5_ireq_valid", ireq_valid, 0);
      check("c5_ireq_addr",  ireq_addr, 64'h8000_0008);
      out_ready = 1'b1;
      tick(); // C6
      check("c6_out_pc",     out_pc, 64'h8000_0004);
      check("c6_out_raw",    out_raw_instr, 32'h8000_0017);
      check("c6_ireq_valid", ireq_valid, 1);
      check("c6_ireq_addr",  ireq_addr, 64'h8000_0008);
      tick(); // C7
      check("c7_out_valid",  out_valid, 0);
      tick(); // C8
      check("c8_out_pc",     out_pc, 64'h8000_0008);
      check("c8_out_raw",    out_raw_instr, 32'h8000_001B);

      // redirect while WAIT, slow memory
      mem_lat = 3;
      tick(); // C9: WAIT
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1000;
      tick(); // C10
      redirect_valid = 1'b0;
      check("c10_ireq_valid", ireq_valid, 0);
      check("c10_ireq_addr",  ireq_addr, 64'h8000_1000);
      tick(); // C11: stale response arrives
      check("c11_iresp",      iresp_valid, 1);
      check("c11_out_valid",  out_valid, 0);
      tick(); // C12
      check("c12_out_valid",  out_valid, 0);
      check("c12_ireq_valid", ireq_valid, 1);
      check("c12_ireq_addr",  ireq_addr, 64'h8000_1000);
      mem_lat = 1;
      tick(); // C13
      out_ready = 1'b0;
      tick(); // C14
      check("c14_out_pc",     out_pc, 64'h8000_1000);
      check("c14_out_raw",    out_raw_instr, 32'h8000_1013);

      // redirect coinciding with response and pop
      tick(); // C15
      check("c15_iresp",      iresp_valid, 1);
      check("c15_out_valid",  out_valid, 1);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      tick(); // C16
      redirect_valid = 1'b0;
      check("c16_out_valid",  out_valid, 0);
      check("c16_ireq_valid", ireq_valid, 1);
      check("c16_ireq_addr",  ireq_addr, 64'h8000_2000);
      tick(); // C17
      tick(); // C18
      check("c18_out_pc",     out_pc, 64'h8000_2000);
      check("c18_out_raw",    out_raw_instr, 32'h8000_2013);

      // misaligned redirect, issued while a request is accepted
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0102;
      tick(); // C19: DISCARD
      redirect_valid = 1'b0;
      check("c19_out_valid",  out_valid, 0);
      check("c19_ireq_valid", ireq_valid, 0);
`ifdef FETCH_MISALIGN_EXC_EN
      check("c19_ireq_addr",  ireq_addr, 64'h8000_0102);
      tick(); // C20
      check("c20_ireq_valid", ireq_valid, 0);
      tick(); // C21
      check("c21_out_valid",  out_valid, 1);
      check("c21_out_pc",     out_pc, 64'h8000_0102);
      check("c21_out_exc",    out_exc, 1);
      check("c21_out_raw",    out_raw_instr, 0);
      tick(); // C22: HALT
      check("c22_ireq_valid", ireq_valid, 0);
      check("c22_out_valid",  out_valid, 0);
`else
      check("c19_ireq_addr",  ireq_addr, 64'h8000_0100);
      tick(); // C20
      check("c20_ireq_valid", ireq_valid, 1);
      check("c20_ireq_addr",  ireq_addr, 64'h8000_0100);
      tick(); // C21
      tick(); // C22
      check("c22_out_pc",     out_pc, 64'h8000_0100);
      check("c22_out_exc",    out_exc, 0);
`endif
      ireq_ready     = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0200;
      tick(); // C23
      redirect_valid = 1'b0;
      ireq_ready     = 1'b1;
      mem_lat        = 3;
      check("c23_ireq_valid", ireq_valid, 1);
      check("c23_ireq_addr",  ireq_addr, 64'h8000_0200);
      tick(); // C24: WAIT
      check("c24_ireq_valid", ireq_valid, 0);

      // reset while WAIT
      reset = 1'b1;
      tick(); // C25
      check("c25_ireq_valid", ireq_valid, 0);
      check("c25_out_valid",  out_valid, 0);
      check("c25_out_pc",     out_pc, 0);
      tick(); // C26
      mem_lat = 1;
      reset   = 1'b0;
      #1;
      check("c26_ireq_valid", ireq_valid, 1);
      check("c26_ireq_addr",  ireq_addr, 64'h8000_0000);
      tick(); // C27
      check("c27_iresp",      iresp_valid, 1);
      tick(); // C28
      check("c28_out_pc",     out_pc, 64'h8000_0000);
      check("c28_out_raw",    out_raw_instr, 32'h8000_0013);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
